// File: rtl/fxp_dot_acc.sv
// fxp_dot_acc: streaming signed fixed-point multiply-accumulate, one saturated wide result per frame
// in_valid/in_ready/in_a/in_b/in_last : operand pair stream, in_last closes the frame
// out_valid/out_ready/out_data        : frame result, held until handshake
// out_ovf/out_trunc/out_len           : saturation seen, frame force-closed at MAXLEN, beat count
module fxp_dot_acc #(
  parameter int WIIA = 8,
  parameter int WIFA = 8,
  parameter int WIIB = 8,
  parameter int WIFB = 8,
  parameter int GUARD = 4,
  parameter int MAXLEN = 64,
  localparam int WOI = WIIA + WIIB + GUARD,
  localparam int WOF = WIFA + WIFB,
  localparam int WA = WOI + WOF,
  localparam int WP = WIIA + WIFA + WIIB + WIFB,
  localparam int LW = $clog2(MAXLEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIIA+WIFA-1:0] in_a,
  input  logic [WIIB+WIFB-1:0] in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WA-1:0]        out_data,
  output logic                 out_ovf,
  output logic                 out_trunc,
  output logic [LW-1:0]        out_len
);
  logic stall, take, force_close, of, ovf;
  logic signed [WP-1:0] prod, p;
  logic p_valid, p_last, p_trunc;
  logic [WA-1:0] acc, sat;
  logic [WA:0] sum;
  logic [LW-1:0] icnt, cnt;
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall & ~rst;
  assign take = in_valid & in_ready;
  assign prod = $signed(in_a) * $signed(in_b);
  // input-side beat count decides the MAXLEN close, since the accumulator count lags by the product stage
  assign force_close = icnt == LW'(MAXLEN - 1);
  assign sum = {acc[WA-1], acc} + {{(WA + 1 - WP){p[WP-1]}}, p};
  assign of = sum[WA] ^ sum[WA-1];
  assign sat = of ? {sum[WA], {(WA - 1){~sum[WA]}}} : sum[WA-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      p_valid <= 1'b0;
      p_last <= 1'b0;
      p_trunc <= 1'b0;
      icnt <= '0;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ovf <= 1'b0;
      out_trunc <= 1'b0;
      out_len <= '0;
    end else if (!stall) begin
      p_valid <= take;
      if (take) begin
        p <= prod;
        p_last <= in_last | force_close;
        p_trunc <= ~in_last & force_close;
        icnt <= (in_last | force_close) ? '0 : icnt + 1'b1;
      end
      out_valid <= 1'b0;
      out_data <= '0;
      out_ovf <= 1'b0;
      out_trunc <= 1'b0;
      out_len <= '0;
      if (p_valid) begin
        acc <= p_last ? '0 : sat;
        cnt <= p_last ? '0 : cnt + 1'b1;
        ovf <= p_last ? 1'b0 : ovf | of;
        if (p_last) begin
          out_valid <= 1'b1;
          out_data <= sat;
          out_ovf <= ovf | of;
          out_trunc <= p_trunc;
          out_len <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fxp_dot_acc.sv
// tb_fxp_dot_acc: self-checking bench for fxp_dot_acc with table vectors, directed corners and a random model check
module tb_fxp_dot_acc;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [35:0] d;
  } vec_t;
  typedef struct {
    logic [35:0] d;
    logic ovf;
    logic trunc;
    logic [6:0] len;
  } exp_t;
  localparam longint MAXV = (64'sd1 <<< 35) - 1;
  localparam longint MINV = -(64'sd1 <<< 35);
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready;
  logic [15:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, out_ovf, out_trunc;
  logic [35:0] out_data;
  logic [6:0] out_len;
  int nchk = 0, nerr = 0, rdy_mode = 1;
  exp_t q[$];
  vec_t tbl[7];
  longint m_acc = 0;
  bit m_ovf = 0;
  int m_len = 0;
  fxp_dot_acc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_trunc(out_trunc), .out_len(out_len)
  );
  always #5 clk = ~clk;
  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    end
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic push_exp(input logic [35:0] d, input logic ovf, input logic trunc, input logic [6:0] len);
    exp_t e;
    e.d = d;
    e.ovf = ovf;
    e.trunc = trunc;
    e.len = len;
    q.push_back(e);
  endtask
  // reference: exact integer sum of products, clamped to the 36-bit signed range after each beat
  task automatic model_beat(input logic [15:0] a, input logic [15:0] b, input bit last);
    longint s;
    s = m_acc + longint'($signed(a)) * longint'($signed(b));
    if (s > MAXV) begin
      s = MAXV;
      m_ovf = 1;
    end else if (s < MINV) begin
      s = MINV;
      m_ovf = 1;
    end
    m_acc = s;
    m_len++;
    if (last || m_len == 64) begin
      push_exp(36'(m_acc), m_ovf, !last, 7'(m_len));
      m_acc = 0;
      m_ovf = 0;
      m_len = 0;
    end
  endtask
  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input bit last);
    int t = 0;
    in_valid = 1;
    in_a = a;
    in_b = b;
    in_last = last;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      nchk++;
      nerr++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask
  task automatic drain(input string name);
    int t = 0;
    while ((q.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(name, 64'(q.size()), 0);
  endtask
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) chk("spurious_out", 64'(q.size()), 1);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_ovf", out_ovf, e.ovf);
        chk("out_trunc", out_trunc, e.trunc);
        chk("out_len", out_len, e.len);
      end
    end
  end
  initial begin
    int t;
    logic [35:0] hold;
    logic [15:0] a, b;
    int len;
    tbl[0] = '{16'h0100, 16'h0100, 36'h000010000};
    tbl[1] = '{16'h8000, 16'h8000, 36'h040000000};
    tbl[2] = '{16'h7FFF, 16'h8000, 36'hFC0008000};
    tbl[3] = '{16'h0001, 16'h0001, 36'h000000001};
    tbl[4] = '{16'hFFFF, 16'h0001, 36'hFFFFFFFFF};
    tbl[5] = '{16'h0000, 16'h1234, 36'h000000000};
    tbl[6] = '{16'hFF80, 16'hFF00, 36'h000008000};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_trunc", out_trunc, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 0;
    push_exp(36'hFFFFD0000, 0, 0, 1);
    send_beat(16'h0180, 16'hFE00, 1);
    @(negedge clk);
    chk("latency_cycle1", out_valid, 0);
    @(negedge clk);
    chk("latency_cycle2", out_valid, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      push_exp(tbl[i].d, 0, 0, 1);
      send_beat(tbl[i].a, tbl[i].b, 1);
    end
    push_exp(36'h000024000, 0, 0, 3);
    send_beat(16'h0180, 16'h0200, 0);
    send_beat(16'h0080, 16'h0080, 0);
    send_beat(16'hFF00, 16'h0100, 1);
    push_exp(36'h7FFFFFFFF, 1, 0, 32);
    for (int i = 1; i <= 32; i++) send_beat(16'h8000, 16'h8000, i == 32);
    push_exp(36'h000010000, 0, 0, 1);
    send_beat(16'h0100, 16'h0100, 1);
    push_exp(36'h000400000, 0, 1, 64);
    push_exp(36'h000060000, 0, 0, 6);
    for (int i = 1; i <= 70; i++) send_beat(16'h0100, 16'h0100, i == 70);
    drain("drain_before_bp");
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    push_exp(36'h000010000, 0, 0, 1);
    send_beat(16'h0100, 16'h0100, 1);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      t++;
      @(negedge clk);
    end
    chk("bp_pending", out_valid, 1);
    hold = out_data;
    @(posedge clk);
    #1;
    in_valid = 1;
    in_a = 16'h0200;
    in_b = 16'h0100;
    in_last = 0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_data", out_data, hold);
      chk("bp_hold_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    rdy_mode = 1;
    push_exp(36'h000050000, 0, 0, 2);
    push_exp(36'hFFFFF0000, 0, 0, 1);
    push_exp(36'h000020000, 0, 0, 2);
    send_beat(16'h0200, 16'h0100, 0);
    rdy_mode = 2;
    send_beat(16'h0100, 16'h0300, 1);
    send_beat(16'hFF00, 16'h0100, 1);
    send_beat(16'h0040, 16'h0400, 0);
    send_beat(16'h0040, 16'h0400, 1);
    rdy_mode = 1;
    drain("drain_before_rst");
    for (int i = 0; i < 5; i++) send_beat(16'h0100, 16'h0100, 0);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_out", out_valid, 0);
    end
    @(posedge clk);
    #1;
    push_exp(36'h000020000, 0, 0, 2);
    send_beat(16'h0100, 16'h0100, 0);
    send_beat(16'h0100, 16'h0100, 1);
    rdy_mode = 2;
    for (int f = 0; f < 24; f++) begin
      len = $urandom_range(1, 80);
      for (int i = 1; i <= len; i++) begin
        a = 16'($urandom);
        b = 16'($urandom);
        if (f % 3 == 0) begin
          a = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
          b = a;
        end else if (f % 3 == 1) begin
          a = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
          b = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
        end
        model_beat(a, b, i == len);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send_beat(a, b, i == len);
      end
    end
    rdy_mode = 1;
    drain("drain_final");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
